// File: rtl/brq_arb_pkg.sv
// Shared definitions for the memory port arbiter: response FSM state
// encoding and the byte-enable code that selects a full 32-bit word.
package brq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LS = 2'd2
  } arb_state_e;

  // Byte-enable code meaning "full word" (same encoding as ldst_byte_en)
  localparam logic [2:0] BE_FULL_WORD = 3'b010;

endpackage : brq_arb_pkg

// File: rtl/arb_starve_cnt.sv
// Saturating 3-bit fetch-starvation counter with synchronous clear.
// sat_o is high while the count sits at Limit.
module arb_starve_cnt #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [2:0] LimitC = 3'(Limit);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: clear wins, otherwise count up until the limit is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (inc_i && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == LimitC);

endmodule : arb_starve_cnt

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. Load/store has priority; grants are combinational and reads
// return data exactly one cycle after the grant.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let a fetch that has
// waited StarveLimit cycles win over load/store for one cycle.
module mem_port_arbiter
  import brq_arb_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 15,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [AddrWidth-1:0] ls_addr,
  input  logic [DataWidth-1:0] ls_wdata,
  input  logic [2:0]           ls_be,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [DataWidth-1:0] ls_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [2:0]           mem_be,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 arb_stall
);

  if ((StarveLimit < 1) || (StarveLimit > 7)) begin : g_bad_limit
    $error("StarveLimit must lie in 1..7");
  end

  arb_state_e state_q;
  arb_state_e state_d;
  logic       starve_fire_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .Limit (StarveLimit)
  ) u_starve_cnt (
    .clk_i (brq_clk),
    .rst_i (brq_rst),
    .inc_i (if_req & ~if_gnt),
    .clr_i (if_gnt | ~if_req),
    .sat_o (starve_fire_s)
  );
`else
  // Fixed load/store priority: fetch never overrides a load/store request
  assign starve_fire_s = 1'b0;
`endif

  // Grant selection and memory command mux; everything forced low in reset
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 3'b000;
    arb_stall = 1'b0;
    if (!brq_rst) begin
      if (if_req && (!ls_req || starve_fire_s)) begin
        if_gnt   = 1'b1;
        mem_req  = 1'b1;
        mem_addr = if_addr;
        mem_be   = BE_FULL_WORD;
      end else if (ls_req) begin
        ls_gnt    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = ls_we;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        mem_be    = ls_be;
      end else begin
        mem_req = 1'b0;
      end
      arb_stall = (if_req & ~if_gnt) | (ls_req & ~ls_gnt);
    end else begin
      arb_stall = 1'b0;
    end
  end

  // Next state: remember which requester owns next cycle's read data
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (ls_gnt && !ls_we) begin
      state_d = RESP_LS;
    end else begin
      state_d = IDLE;
    end
  end

  // Response state register; reset drops any in-flight read
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Route memory read data to the owner of the response cycle
  always_comb begin
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    case (state_q)
      RESP_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      RESP_LS: begin
        ls_rvalid = 1'b1;
        ls_rdata  = mem_rdata;
      end
      default: begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
      end
    endcase
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Expectations for the starvation scenario follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic        brq_clk = 1'b0;
  logic        brq_rst;
  logic        if_req;
  logic [14:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [14:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_be;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        arb_stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [120:0] all_out;
  assign all_out = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                    mem_req, mem_we, mem_addr, mem_wdata, mem_be, arb_stall};

  mem_port_arbiter dut (
    .brq_clk   (brq_clk),
    .brq_rst   (brq_rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .arb_stall (arb_stall)
  );

  always #5 brq_clk = ~brq_clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 15'h0000;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = 15'h0000;
    ls_wdata  = 32'h0000_0000;
    ls_be     = 3'b000;
    mem_rdata = 32'h0000_0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    if_req  = 1'b1;
    ls_req  = 1'b1;
    brq_rst = 1'b1;
    #3;
    n_cmp++;
    if (all_out !== 121'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    idle_inputs();
    tick();
    brq_rst = 1'b0;
    tick();
    n_cmp++;
    if (all_out !== 121'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_fetch_only();
    if_req  = 1'b1;
    if_addr = 15'h0010;
    #2;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, arb_stall}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 15'h0010, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_grant: got gnt=%b/%b req=%b we=%b be=%b addr=%h wd=%h stall=%b",
               if_gnt, ls_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, arb_stall);
    end
    tick();
    if_req    = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++;
    if ({if_rvalid, if_rdata, ls_rvalid, mem_req, arb_stall}
        !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_resp: got rv=%b rd=%h lsrv=%b req=%b want rv=1 rd=deadbeef",
               if_rvalid, if_rdata, ls_rvalid, mem_req);
    end
    tick();
    #2;
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL fetch_after: got rv=%b rd=%h want 0/0", if_rvalid, if_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_conflict();
    if_req  = 1'b1;
    if_addr = 15'h0044;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 15'h0200;
    #2;
    n_cmp++;
    if ({ls_gnt, if_gnt, mem_req, mem_we, mem_addr, arb_stall}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 15'h0200, 1'b1}) begin
      n_bad++;
      $display("FAIL conflict_grant: got ls=%b if=%b req=%b we=%b addr=%h stall=%b",
               ls_gnt, if_gnt, mem_req, mem_we, mem_addr, arb_stall);
    end
    tick();
    ls_req    = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    #2;
    n_cmp++;
    if ({ls_rvalid, ls_rdata, if_rvalid, if_gnt, ls_gnt, mem_addr, mem_be, arb_stall}
        !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 15'h0044, 3'b010, 1'b0}) begin
      n_bad++;
      $display("FAIL conflict_next: got lsrv=%b lsrd=%h ifrv=%b ifg=%b lsg=%b addr=%h be=%b stall=%b",
               ls_rvalid, ls_rdata, if_rvalid, if_gnt, ls_gnt, mem_addr, mem_be, arb_stall);
    end
    tick();
    if_req    = 1'b0;
    mem_rdata = 32'h0BAD_CAFE;
    #2;
    n_cmp++;
    if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata} !== {1'b1, 32'h0BAD_CAFE, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL conflict_fetch_resp: got ifrv=%b ifrd=%h lsrv=%b lsrd=%h",
               if_rvalid, if_rdata, ls_rvalid, ls_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_store();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 15'h0123;
    ls_wdata = 32'h1234_5678;
    ls_be    = 3'b001;
    #2;
    n_cmp++;
    if ({ls_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be, arb_stall}
        !== {1'b1, 1'b1, 1'b1, 15'h0123, 32'h1234_5678, 3'b001, 1'b0}) begin
      n_bad++;
      $display("FAIL store_cmd: got g=%b req=%b we=%b addr=%h wd=%h be=%b stall=%b",
               ls_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be, arb_stall);
    end
    tick();
    idle_inputs();
    mem_rdata = 32'h5555_AAAA;
    #2;
    n_cmp++;
    if ({ls_rvalid, if_rvalid, ls_rdata, if_rdata} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL store_no_rvalid: got lsrv=%b ifrv=%b lsrd=%h ifrd=%h want all 0",
               ls_rvalid, if_rvalid, ls_rdata, if_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic prev_if;
    logic prev_ls;
    logic exp_if;
    prev_if = 1'b0;
    prev_ls = 1'b0;
    if_req  = 1'b1;
    if_addr = 15'h0077;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 15'h0300;
    for (int i = 0; i < 12; i++) begin
      mem_rdata = 32'hA000_0000 + 32'(i);
      #2;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (i == 4) || (i == 9);
`else
      exp_if = 1'b0;
`endif
      n_cmp++;
      if ({if_gnt, ls_gnt, arb_stall, if_rvalid, ls_rvalid}
          !== {exp_if, ~exp_if, 1'b1, prev_if, prev_ls}) begin
        n_bad++;
        $display("FAIL starve_cycle%0d: got ifg=%b lsg=%b stall=%b ifrv=%b lsrv=%b want ifg=%b lsg=%b stall=1 ifrv=%b lsrv=%b",
                 i, if_gnt, ls_gnt, arb_stall, if_rvalid, ls_rvalid,
                 exp_if, ~exp_if, prev_if, prev_ls);
      end
      prev_if = exp_if;
      prev_ls = ~exp_if;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_read();
    if_req  = 1'b1;
    if_addr = 15'h0005;
    #2;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_grant: got %b want 1", if_gnt);
    end
    brq_rst = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 121'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h want 0", all_out);
    end
    if_req    = 1'b0;
    mem_rdata = 32'h7777_7777;
    tick();
    brq_rst = 1'b0;
    #1;
    n_cmp++;
    if ({if_rvalid, if_rdata, ls_rvalid} !== {1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_release: got rv=%b rd=%h lsrv=%b want 0", if_rvalid, if_rdata, ls_rvalid);
    end
    tick();
    n_cmp++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_after: got rv=%b/%b want 00", if_rvalid, ls_rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [3];
    dat[0] = 32'h1111_0001;
    dat[1] = 32'h2222_0002;
    dat[2] = 32'h3333_0003;
    for (int k = 0; k < 5; k++) begin
      if_req    = (k < 3);
      if_addr   = (k < 3) ? 15'(k + 1) : 15'h0000;
      mem_rdata = (k >= 1 && k <= 3) ? dat[k-1] : 32'hFFFF_FFFF;
      #2;
      n_cmp++;
      if ({if_gnt, mem_req, mem_addr} !== {(k < 3), (k < 3), ((k < 3) ? 15'(k + 1) : 15'h0)}) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got g=%b req=%b addr=%h", k, if_gnt, mem_req, mem_addr);
      end
      n_cmp++;
      if ({if_rvalid, if_rdata}
          !== {(k >= 1 && k <= 3), ((k >= 1 && k <= 3) ? dat[k-1] : 32'h0)}) begin
        n_bad++;
        $display("FAIL b2b_resp%0d: got rv=%b rd=%h", k, if_rvalid, if_rdata);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    brq_rst = 1'b1;
    #1;
    test_reset();
    test_fetch_only();
    test_conflict();
    test_store();
    test_starvation();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
